// File: rtl/mips_cpu_bus_arbiter.sv
// Shares one Avalon master port between instruction fetch and data load/store.
// Registered command, waitrequest hold, read-data return and stall watchdog.
module mips_cpu_bus_arbiter #(
   parameter int PRIORITY       = 0,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DATA,
      S_RESP
   } state_e;

   localparam logic OWN_I  = 1'b0;
   localparam logic OWN_D  = 1'b1;
   localparam logic PRIO_D = (PRIORITY != 0);
   localparam logic WD_EN  = (TIMEOUT_CYCLES > 0);
   localparam int   CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] WD_LAST =
      (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic          first_q, first_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic [31:0]   irdata_q, irdata_d;
   logic [31:0]   drdata_q, drdata_d;
   logic          err_q, err_d;
   logic [CW-1:0] wd_q, wd_d;

   logic any_req;
   logic sel_d;
   logic wd_hit;

   assign any_req = i_req | d_req;
   // Data wins when alone, under fixed priority, or when fetch owned last.
   assign sel_d   = d_req & (~i_req | PRIO_D | (last_q == OWN_I));
   assign wd_hit  = WD_EN & waitrequest & (wd_q == WD_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (any_req) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (!waitrequest) begin
               state_d = rd_q ? S_DATA : S_IDLE;
            end else if (wd_hit) begin
               state_d = rd_q ? S_RESP : S_IDLE;
            end
         end
         S_DATA:  state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      owner_d  = owner_q;
      last_d   = last_q;
      first_d  = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      err_d    = err_q;
      wd_d     = wd_q;
      unique case (state_q)
         S_IDLE: begin
            if (any_req) begin
               owner_d = sel_d;
               last_d  = sel_d;
               first_d = 1'b1;
               wd_d    = '0;
               if (sel_d) begin
                  addr_d  = d_addr;
                  rd_d    = ~d_we;
                  wr_d    = d_we;
                  be_d    = d_be;
                  wdata_d = d_wdata;
               end else begin
                  addr_d  = i_addr;
                  rd_d    = 1'b1;
                  wr_d    = 1'b0;
                  be_d    = 4'b1111;
                  wdata_d = '0;
               end
            end
         end
         S_ISSUE: begin
            if (!waitrequest) begin
               rd_d = 1'b0;
               wr_d = 1'b0;
            end else if (wd_hit) begin
               rd_d  = 1'b0;
               wr_d  = 1'b0;
               err_d = 1'b1;
               // An aborted read still completes, returning zero.
               if (rd_q) begin
                  if (owner_q == OWN_D) drdata_d = '0;
                  else                  irdata_d = '0;
               end
            end else begin
               wd_d = wd_q + CW'(1);
            end
         end
         S_DATA: begin
            if (owner_q == OWN_D) drdata_d = readdata;
            else                  irdata_d = readdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         owner_q  <= OWN_I;
         last_q   <= OWN_I;
         first_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
         err_q    <= 1'b0;
         wd_q     <= '0;
      end else begin
         owner_q  <= owner_d;
         last_q   <= last_d;
         first_q  <= first_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
         err_q    <= err_d;
         wd_q     <= wd_d;
      end
   end

   always_comb begin
      i_gnt      = (state_q == S_ISSUE) & first_q & (owner_q == OWN_I);
      d_gnt      = (state_q == S_ISSUE) & first_q & (owner_q == OWN_D);
      i_rvalid   = (state_q == S_RESP) & (owner_q == OWN_I);
      d_rvalid   = (state_q == S_RESP) & (owner_q == OWN_D);
      busy       = (state_q != S_IDLE);
      address    = addr_q;
      read       = rd_q;
      write      = wr_q;
      writedata  = wdata_q;
      byteenable = be_q;
      i_rdata    = irdata_q;
      d_rdata    = drdata_q;
      err        = err_q;
   end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
Name: mips_cpu_bus_arbiter

Overview:
- Shares the single Avalon memory-mapped master port of mips_cpu_bus between two requesters: instruction fetch (read-only) and data load/store (read/write).
- Sits between the CPU state machine (fetch/memory states) and the external Avalon bus.
- Arbitrates, registers the winning command, holds it through waitrequest stalls, and returns read data to the owner.
- Detects stuck transfers with a watchdog.

Parameters:
- PRIORITY, 0: 0 = round-robin on simultaneous requests; 1 = data port always wins ties.
- TIMEOUT_CYCLES, 64: maximum consecutive waitrequest-high cycles in ISSUE before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 sampled at posedge resets the block)
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  32  fetch word address
- i_gnt  out  1  one-cycle pulse: fetch command accepted
- i_rvalid  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  32  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_be  in  4  store/load byte enables
- d_gnt  out  1  one-cycle pulse: data command accepted
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (reads only)
- d_rdata  out  32  load data
- address  out  32  Avalon address
- read  out  1  Avalon read request
- write  out  1  Avalon write request
- writedata  out  32  Avalon write data
- byteenable  out  4  Avalon byte enables
- waitrequest  in  1  Avalon stall
- readdata  in  32  Avalon read data, valid the cycle after the accepted read
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky watchdog-abort flag

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs 0 (address, writedata, byteenable, read, write, gnts, rvalids, rdatas, busy, err); last_owner = FETCH.
- A reset during ISSUE, DATA or RESP abandons the transfer. No gnt or rvalid is produced for it. read/write are 0 from the cycle after the reset edge.
- States: IDLE, ISSUE, DATA, RESP.
- IDLE: req inputs are sampled only in this state.
  - Neither request: stay in IDLE.
  - One request: that requester is selected.
  - Both, PRIORITY=1: data is selected.
  - Both, PRIORITY=0: the requester that is not last_owner is selected. After reset, data wins the first tie.
- On selection, at the edge, register the command and go to ISSUE. last_owner is updated to the selected requester.
  - Fetch command: address = i_addr, read = 1, write = 0, byteenable = 4'b1111, writedata = 0.
  - Data command: address = d_addr, read = !d_we, write = d_we, byteenable = d_be, writedata = d_wdata.
- ISSUE:
  - The owner's gnt is high in the first ISSUE cycle only.
  - The command is held stable while waitrequest==1.
  - With waitrequest==0, the transfer is accepted at that edge: read and write drop to 0.
  - After an accepted read, go to DATA. After an accepted write, go to IDLE.
- Minimum latencies:
  - Write: IDLE→ISSUE→IDLE, 2 cycles.
  - Read: IDLE→ISSUE→DATA→RESP, with rvalid in cycle 4.
- DATA: readdata is captured into the owner's rdata register; go to RESP.
- RESP: the owner's rvalid = 1 for one cycle; go to IDLE. rdata holds its value until the next read for that owner.
- Requester obligation: deassert req in the cycle after its gnt unless a new request is being presented. A new request can be granted no earlier than the first IDLE cycle after the current transfer.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter counts consecutive ISSUE cycles with waitrequest==1 and resets on entering ISSUE.
  - When the count reaches TIMEOUT_CYCLES: drop read/write and set err = 1 (sticky until reset).
  - Read abort: go to RESP with owner rdata = 32'h0.
  - Write abort: go to IDLE.
- Addresses and byteenables pass unmodified. No alignment checking.
- busy = (state != IDLE).
- Address 32'h00000000 has no special meaning to this block; halt detection stays in the CPU.

Test Plan:
- Single fetch, i_addr=32'hBFC00000, waitrequest=0, readdata=32'h24020005 in the following cycle -> address=BFC00000, read=1 for 1 cycle, i_gnt pulses in cycle 2, i_rvalid=1 with i_rdata=24020005 in cycle 4.
- Data store, d_addr=32'h00001000, d_wdata=32'hDEADBEEF, d_be=4'b0011, waitrequest high 3 cycles -> write held 4 cycles with stable address/data/byteenable, d_gnt only in first ISSUE cycle, no d_rvalid, busy low in cycle 6.
- Simultaneous i_req and d_req after reset, PRIORITY=0 -> data granted first, fetch second. Repeat tie -> data then fetch again (alternation). With PRIORITY=1 -> data always first.
- Back-to-back reads: d_req held through two requests -> second grant occurs only after first d_rvalid; no overlap of read pulses.
- Watchdog, TIMEOUT_CYCLES=4, waitrequest stuck high on a fetch -> read drops after 4 stall cycles, err=1 and stays 1, i_rvalid pulses with i_rdata=0, next request serviced normally.
- Reset asserted (reset=0) during DATA of a load -> next cycle read=0, busy=0, err=0, no d_rvalid; subsequent fetch behaves as in the first scenario.
